reg16_bank_arbiter: RTL and testbench

Controller that shares a small bank of 16-bit registers (cs/w/r-strobed Reg16Bit-style slots) between two requesters. Each requester issues single read or write transactions through a req/done handshake. The block arbitrates, latches the winning command, and drives the bank's chip-select, write and read strobes for exactly one access cycle. It returns read data with a one-cycle done pulse, and sits between the two bus masters and the register bank datapath.

---
 rtl/reg16_bank_arbiter_pkg.sv | 23 ++
 rtl/reg16_bank_arbiter_if.sv | 51 +++++
 rtl/reg16_bank_arbiter_rr_arb2.sv | 53 +++++
 rtl/reg16_bank_arbiter.sv | 137 +++++++++++++
 tb/tb_reg16_bank_arbiter.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/reg16_bank_arbiter_pkg.sv
// Shared types and constants for the two-requester register bank arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: FSM state encoding, default data width, and the reset value of
// the round-robin last-served pointer.
package reg_arb_pkg;

    // Transaction FSM: one arbitration sample, one bank access, one done cycle.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    // Default register data width.
    localparam int DW_DEFAULT = 16;

    // Last-served pointer reset value. 1 means "requester 1 was served last",
    // so requester 0 wins the first tie after reset.
    localparam logic PTR_RST = 1'b1;

endpackage : reg_arb_pkg

// File: rtl/reg16_bank_arbiter_if.sv
// Bundle of requester handshakes and register bank strobes for reg16_bank_arbiter.
// Latency: n/a (wires only).
// Backpressure: req is held with a stable command until the matching done pulse.
//
// Ports (signals):
//   req0/1, we0/1, addr0/1, wdata0/1 : requester commands
//   gnt0/1, done0/1, rdata           : requester responses
//   reg_cs, reg_w, reg_r, reg_din    : bank strobes and write data
//   reg_dout                         : muxed bank read data
// Modports: slave = arbiter side, master = requesters plus bank side.
interface reg16_bank_arbiter_if #(
    parameter int NUM_REGS = 4,
    parameter int DW       = reg_arb_pkg::DW_DEFAULT,
    parameter int AW       = $clog2(NUM_REGS)
);

    // Requester commands
    logic                req0;
    logic                req1;
    logic                we0;
    logic                we1;
    logic [AW-1:0]       addr0;
    logic [AW-1:0]       addr1;
    logic [DW-1:0]       wdata0;
    logic [DW-1:0]       wdata1;

    // Requester responses
    logic                gnt0;
    logic                gnt1;
    logic                done0;
    logic                done1;
    logic [DW-1:0]       rdata;

    // Register bank side
    logic [NUM_REGS-1:0] reg_cs;
    logic                reg_w;
    logic                reg_r;
    logic [DW-1:0]       reg_din;
    logic [DW-1:0]       reg_dout;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, reg_dout,
        output gnt0, gnt1, done0, done1, rdata, reg_cs, reg_w, reg_r, reg_din
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, reg_dout,
        input  gnt0, gnt1, done0, done1, rdata, reg_cs, reg_w, reg_r, reg_din
    );

endinterface : reg16_bank_arbiter_if

// File: rtl/reg16_bank_arbiter_rr_arb2.sv
// Two-way winner select for the register bank arbiter.
// Latency: combinational winner; pointer updates on the edge where take is high.
// Backpressure: none; losers simply keep requesting until they win.
//
// Ports: clk, rst (sync, active-high), req0, req1, take (winner accepted this
//        cycle), win1 (1 = requester 1 wins), any (some request present).
// Macro REG_ARB_RR_EN: defined = round-robin with a last-served pointer;
//        undefined = fixed priority, requester 0 wins ties, no pointer flop.
module rr_arb2
    import reg_arb_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic req0,
    input  logic req1,
    input  logic take,
    output logic win1,
    output logic any
);

    assign any = req0 | req1;

`ifdef REG_ARB_RR_EN
    // 1 = requester 1 was served last, 0 = requester 0 was served last.
    logic last;

    always_ff @(posedge clk) begin
        if (rst) begin
            last <= PTR_RST;
        end else if (take) begin
            last <= win1;
        end
    end

    // On a tie, serve whoever was not served last; otherwise the lone requester.
    always_comb begin
        win1 = req1;
        if (req0 && req1) begin
            win1 = ~last;
        end
    end
`else
    // Requester 0 always wins a tie.
    always_comb begin
        win1 = req1 & ~req0;
    end

    // Clock, reset and take have no state to drive in this configuration.
    logic unused_fixed_prio;
    assign unused_fixed_prio = ^{clk, rst, take};
`endif

endmodule : rr_arb2

// File: rtl/reg16_bank_arbiter.sv
// Shares a bank of NUM_REGS x DW registers between two req/done requesters.
// Latency: req seen at edge N -> ACCESS N..N+1, done pulse N+1..N+2 (3 cycles min).
// Backpressure: losing/queued requester holds req; commands are latched at grant.
//
// Ports:
//   clk  : clock, all state changes on the rising edge
//   rst  : synchronous reset, active-high, overrides every other input
//   bus  : reg16_bank_arbiter_if.slave (requester commands/responses, bank strobes)
// Arbitration policy lives in rr_arb2 (round-robin when REG_ARB_RR_EN is defined,
// fixed priority for requester 0 otherwise).
module reg16_bank_arbiter
    import reg_arb_pkg::*;
#(
    parameter int NUM_REGS = 4,
    parameter int DW       = DW_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    reg16_bank_arbiter_if.slave   bus
);

    localparam int AW = $clog2(NUM_REGS);

    state_t          state;
    state_t          state_nxt;

    // Latched command of the current owner
    logic            cmd_owner;     // 0 = requester 0, 1 = requester 1
    logic            cmd_we;
    logic [AW-1:0]   cmd_addr;
    logic [DW-1:0]   cmd_wdata;
    logic [DW-1:0]   rdata_q;

    logic            win1;
    logic            any;
    logic            grant;
    logic            addr_ok;

    // A grant happens only from IDLE; this is also the pointer update strobe.
    assign grant = (state == IDLE) && any;

    // Slots beyond NUM_REGS exist in the address space when NUM_REGS is not a
    // power of two; such accesses select nothing and read back zero.
    assign addr_ok = ({1'b0, cmd_addr} < (AW+1)'(NUM_REGS));

    rr_arb2 u_arb (
        .clk  (clk),
        .rst  (rst),
        .req0 (bus.req0),
        .req1 (bus.req1),
        .take (grant),
        .win1 (win1),
        .any  (any)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Command latch: requesters may drop req or change the command once granted.
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_owner <= 1'b0;
            cmd_we    <= 1'b0;
            cmd_addr  <= '0;
            cmd_wdata <= '0;
        end else if (grant) begin
            cmd_owner <= win1;
            cmd_we    <= win1 ? bus.we1    : bus.we0;
            cmd_addr  <= win1 ? bus.addr1  : bus.addr0;
            cmd_wdata <= win1 ? bus.wdata1 : bus.wdata0;
        end
    end

    // Read capture on the edge closing ACCESS; writes leave rdata untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else if ((state == ACCESS) && !cmd_we) begin
            rdata_q <= addr_ok ? bus.reg_dout : '0;
        end
    end

    assign bus.rdata = rdata_q;

    // Next state and all decoded outputs
    always_comb begin
        state_nxt   = state;
        bus.gnt0    = 1'b0;
        bus.gnt1    = 1'b0;
        bus.done0   = 1'b0;
        bus.done1   = 1'b0;
        bus.reg_cs  = '0;
        bus.reg_w   = 1'b0;
        bus.reg_r   = 1'b0;
        bus.reg_din = '0;

        case (state)
            IDLE: begin
                if (any) begin
                    state_nxt = ACCESS;
                end
            end

            ACCESS: begin
                bus.gnt0    = ~cmd_owner;
                bus.gnt1    =  cmd_owner;
                // One-hot select; an out-of-range address matches no slot.
                for (int i = 0; i < NUM_REGS; i++) begin
                    bus.reg_cs[i] = (cmd_addr == AW'(i));
                end
                bus.reg_w   =  cmd_we;
                bus.reg_r   = ~cmd_we;
                bus.reg_din =  cmd_wdata;
                state_nxt   = DONE;
            end

            DONE: begin
                bus.gnt0  = ~cmd_owner;
                bus.gnt1  =  cmd_owner;
                bus.done0 = ~cmd_owner;
                bus.done1 =  cmd_owner;
                state_nxt = IDLE;
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule : reg16_bank_arbiter

// File: tb/tb_reg16_bank_arbiter.sv
// Bench for reg16_bank_arbiter: NUM_REGS=4 and NUM_REGS=3 instances fed the
// same requester stimulus, each with its own behavioural register bank.
module tb_reg16_bank_arbiter;
    import reg_arb_pkg::*;

`ifdef REG_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        req0, req1, we0, we1;
    logic [1:0]  addr0, addr1;
    logic [15:0] wdata0, wdata1;

    reg16_bank_arbiter_if #(.NUM_REGS(4), .DW(16)) i4 ();
    reg16_bank_arbiter_if #(.NUM_REGS(3), .DW(16)) i3 ();

    assign i4.req0 = req0;    assign i3.req0 = req0;
    assign i4.req1 = req1;    assign i3.req1 = req1;
    assign i4.we0 = we0;      assign i3.we0 = we0;
    assign i4.we1 = we1;      assign i3.we1 = we1;
    assign i4.addr0 = addr0;  assign i3.addr0 = addr0;
    assign i4.addr1 = addr1;  assign i3.addr1 = addr1;
    assign i4.wdata0 = wdata0; assign i3.wdata0 = wdata0;
    assign i4.wdata1 = wdata1; assign i3.wdata1 = wdata1;

    reg16_bank_arbiter #(.NUM_REGS(4), .DW(16)) dut4 (.clk(clk), .rst(rst), .bus(i4));
    reg16_bank_arbiter #(.NUM_REGS(3), .DW(16)) dut3 (.clk(clk), .rst(rst), .bus(i3));

    // Behavioural banks: capture on the edge when reg_w is high, read combinationally.
    logic [15:0] bank4 [4];
    logic [15:0] bank3 [3];

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (rst) bank4[i] <= 16'h0;
            else if (i4.reg_w && i4.reg_cs[i]) bank4[i] <= i4.reg_din;
        end
        for (int i = 0; i < 3; i++) begin
            if (rst) bank3[i] <= 16'h0;
            else if (i3.reg_w && i3.reg_cs[i]) bank3[i] <= i3.reg_din;
        end
    end

    // Unselected reads return a junk pattern so a missing zero-fill shows up.
    always_comb begin
        i4.reg_dout = 16'hDEAD;
        for (int i = 0; i < 4; i++) if (i4.reg_r && i4.reg_cs[i]) i4.reg_dout = bank4[i];
        i3.reg_dout = 16'hDEAD;
        for (int i = 0; i < 3; i++) if (i3.reg_r && i3.reg_cs[i]) i3.reg_dout = bank3[i];
    end

    // Observation mux: dsel=1 watches the NUM_REGS=3 instance.
    logic        dsel;
    logic        o_gnt0, o_gnt1, o_done0, o_done1, o_w, o_r;
    logic [15:0] o_cs, o_din, o_rdata;

    always_comb begin
        o_cs = 16'h0;
        if (dsel) begin
            o_gnt0 = i3.gnt0; o_gnt1 = i3.gnt1; o_done0 = i3.done0; o_done1 = i3.done1;
            o_w = i3.reg_w; o_r = i3.reg_r; o_din = i3.reg_din; o_rdata = i3.rdata;
            o_cs[2:0] = i3.reg_cs;
        end else begin
            o_gnt0 = i4.gnt0; o_gnt1 = i4.gnt1; o_done0 = i4.done0; o_done1 = i4.done1;
            o_w = i4.reg_w; o_r = i4.reg_r; o_din = i4.reg_din; o_rdata = i4.rdata;
            o_cs[3:0] = i4.reg_cs;
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: last served requester and bank contents of the 4-slot instance.
    bit          m_last;
    logic [15:0] m_bank [4];

    function automatic int pick_first(input bit r0, input bit r1);
        if (r0 && r1) return RR ? (m_last ? 0 : 1) : 0;
        return r0 ? 0 : 1;
    endfunction

    task automatic chk_quiet(input string tag);
        chk({tag, "_ctl4"}, {i4.gnt0, i4.gnt1, i4.done0, i4.done1, i4.reg_w, i4.reg_r, i4.reg_cs}, 0);
        chk({tag, "_dat4"}, {i4.reg_din, i4.rdata}, 0);
        chk({tag, "_ctl3"}, {i3.gnt0, i3.gnt1, i3.done0, i3.done1, i3.reg_w, i3.reg_r, i3.reg_cs}, 0);
        chk({tag, "_dat3"}, {i3.reg_din, i3.rdata}, 0);
    endtask

    task automatic idle_inputs();
        req0 = 0; req1 = 0; we0 = 0; we1 = 0;
        addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
    endtask

    task automatic do_reset();
        rst = 1; idle_inputs();
        repeat (2) @(negedge clk);
        rst = 0; m_last = 1'b1;
    endtask

    typedef struct {
        bit          d3;
        bit          rq;
        bit          we;
        logic [1:0]  addr;
        logic [15:0] wdata;
        logic [15:0] exp_cs;
        logic [15:0] exp_rd;
    } vec_t;

    // One single-requester transaction, checked cycle by cycle.
    task automatic apply_vec(input vec_t v, input int k);
        string s;
        s = $sformatf("v%0d", k);
        dsel = v.d3;
        if (v.rq) begin req1 = 1; we1 = v.we; addr1 = v.addr; wdata1 = v.wdata; end
        else      begin req0 = 1; we0 = v.we; addr0 = v.addr; wdata0 = v.wdata; end
        @(negedge clk);  // ACCESS
        chk({s, "_gnt_own"}, v.rq ? o_gnt1 : o_gnt0, 1);
        chk({s, "_gnt_oth"}, v.rq ? o_gnt0 : o_gnt1, 0);
        chk({s, "_cs"}, o_cs, v.exp_cs);
        chk({s, "_w"}, o_w, v.we);
        chk({s, "_r"}, o_r, !v.we);
        chk({s, "_din"}, o_din, v.wdata);
        @(negedge clk);  // DONE
        chk({s, "_done"}, v.rq ? o_done1 : o_done0, 1);
        chk({s, "_strobes_off"}, {o_w, o_r, o_cs}, 0);
        chk({s, "_rdata"}, o_rdata, v.exp_rd);
        req0 = 0; req1 = 0;
        @(negedge clk);  // IDLE
        chk({s, "_done_clr"}, {o_done0, o_done1, o_gnt0, o_gnt1}, 0);
        chk({s, "_rdata_hold"}, o_rdata, v.exp_rd);
        m_last = v.rq;
    endtask

    // Present one or two requests and check completion order and read data
    // against the model. Each requester drops req right after its done.
    task automatic serve_round(input bit r0, input bit r1, input bit w0, input bit w1,
                               input logic [1:0] a0, input logic [1:0] a1,
                               input logic [15:0] d0, input logic [15:0] d1);
        int ord [2];
        bit          tw [2];
        logic [1:0]  ta [2];
        logic [15:0] td [2];
        int n, idx, cyc;
        tw[0] = w0; tw[1] = w1; ta[0] = a0; ta[1] = a1; td[0] = d0; td[1] = d1;
        ord[0] = pick_first(r0, r1);
        ord[1] = (r0 && r1) ? 1 - ord[0] : ord[0];
        n = int'(r0) + int'(r1);
        dsel = 0;
        req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
        req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
        idx = 0; cyc = 0;
        while (idx < n && cyc < 30) begin
            @(negedge clk);
            cyc++;
            if (o_done0 || o_done1) begin
                int who;
                int e;
                who = o_done1 ? 1 : 0;
                e = ord[idx];
                chk("arb_order", who, e);
                chk("gnt_excl", {o_gnt0, o_gnt1}, who ? 2'b01 : 2'b10);
                if (tw[e]) m_bank[ta[e]] = td[e];
                else       chk("rd_model", o_rdata, m_bank[ta[e]]);
                m_last = e[0];
                if (who == 1) req1 = 0; else req0 = 0;
                idx++;
            end
        end
        if (idx < n) chk("round_timeout", idx, n);
        req0 = 0; req1 = 0;
    endtask

    vec_t vt [9];

    initial begin
        vt[0] = '{0, 0, 1, 2'd2, 16'd1465,  16'b0100, 16'd0};
        vt[1] = '{0, 1, 0, 2'd2, 16'd0,     16'b0100, 16'd1465};
        vt[2] = '{0, 0, 1, 2'd1, 16'd325,   16'b0010, 16'd1465};
        vt[3] = '{0, 1, 0, 2'd1, 16'h1111,  16'b0010, 16'd325};
        vt[4] = '{1, 0, 0, 2'd2, 16'd0,     16'b0100, 16'd1465};
        vt[5] = '{1, 1, 0, 2'd3, 16'h2222,  16'b0000, 16'd0};
        vt[6] = '{0, 0, 0, 2'd3, 16'd0,     16'b1000, 16'd0};
        vt[7] = '{1, 0, 1, 2'd0, 16'hBEEF,  16'b0001, 16'd0};
        vt[8] = '{0, 1, 0, 2'd0, 16'd0,     16'b0001, 16'hBEEF};

        dsel = 0;
        for (int i = 0; i < 4; i++) m_bank[i] = 16'h0;

        // Reset state, both while held and just after release
        do_reset();
        chk_quiet("rst_held");
        @(negedge clk);
        chk_quiet("rst_rel");

        // Table of single-requester transactions on both bank sizes
        for (int k = 0; k < 9; k++) apply_vec(vt[k], k);

        // Command is latched: drop req and change addr while in ACCESS
        dsel = 0;
        req0 = 1; we0 = 0; addr0 = 2'd1; wdata0 = 16'h0;
        @(negedge clk);
        req0 = 0; addr0 = 2'd3;
        #1;
        chk("latch_cs", o_cs, 16'b0010);
        chk("latch_gnt", o_gnt0, 1);
        @(negedge clk);
        chk("latch_done", o_done0, 1);
        chk("latch_rdata", o_rdata, 16'd325);
        m_last = 1'b0;
        @(negedge clk);

        // Reset in the middle of a write; pointer must come back to "1 served last"
        req0 = 1; we0 = 1; addr0 = 2'd3; wdata0 = 16'd724;
        @(negedge clk);
        chk("abort_w", o_w, 1);
        rst = 1; req0 = 0;
        @(negedge clk);
        chk_quiet("abort");
        rst = 0; m_last = 1'b1;
        @(negedge clk);
        chk("abort_no_done", {i4.done0, i4.done1, i3.done0, i3.done1}, 0);
        serve_round(1, 1, 1, 1, 2'd0, 2'd1, 16'h0A0A, 16'h0B0B);

        // Randomised rounds against the model; first give every slot a known value
        for (int a = 0; a < 4; a++)
            serve_round(1, 0, 1, 0, 2'(a), 2'd0, 16'($urandom), 16'h0);
        for (int k = 0; k < 120; k++) begin
            logic [1:0] rq;
            rq = 2'($urandom_range(1, 3));
            serve_round(rq[0], rq[1], 1'($urandom), 1'($urandom),
                        2'($urandom), 2'($urandom), 16'($urandom), 16'($urandom));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        // Both requesters held continuously: grants alternate under round-robin,
        // requester 0 monopolises under fixed priority
        do_reset();
        dsel = 0;
        req0 = 1; we0 = 1; addr0 = 2'd0; wdata0 = 16'd325;
        req1 = 1; we1 = 1; addr1 = 2'd1; wdata1 = 16'd4362;
        begin
            int got = 0;
            int cyc = 0;
            while (got < 4 && cyc < 40) begin
                @(negedge clk);
                cyc++;
                if (o_done0 || o_done1) begin
                    chk($sformatf("alt%0d", got), o_done1 ? 1 : 0, RR ? (got % 2) : 0);
                    got++;
                end
            end
            if (got < 4) chk("alt_timeout", got, 4);
        end
        idle_inputs();
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_reg16_bank_arbiter
